// File: rtl/nonce_result_scanner.sv
// Scans NUM_NONCES hash result words in shared memory, tracks the minimum hash and
// the count of words below the target, then writes a two-word report record.
module nonce_result_scanner #(
  parameter int NUM_NONCES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] result_addr,
  input  logic [15:0] report_addr,
  input  logic [31:0] target,
  output logic        done,
  output logic        found,
  output logic [7:0]  match_count,
  output logic [7:0]  best_nonce,
  output logic [31:0] best_hash,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam logic [7:0] LAST_IDX = 8'(NUM_NONCES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_HDR,
    S_WR_HASH
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [15:0] res_base_q, res_base_d;
  logic [15:0] rep_base_q, rep_base_d;
  logic [31:0] target_q, target_d;
  logic        found_q, found_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  bnonce_q, bnonce_d;
  logic [31:0] bhash_q, bhash_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        hit_best, hit_tgt;

  assign hit_best = mem_read_data < bhash_q;
  assign hit_tgt  = mem_read_data < target_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    res_base_d = res_base_q;
    rep_base_d = rep_base_q;
    target_d   = target_q;
    found_d    = found_q;
    cnt_d      = cnt_q;
    bnonce_d   = bnonce_q;
    bhash_d    = bhash_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          res_base_d = result_addr;
          rep_base_d = report_addr;
          target_d   = target;
          found_d    = 1'b0;
          cnt_d      = 8'd0;
          idx_d      = 8'd0;
          bnonce_d   = 8'd0;
          bhash_d    = 32'hFFFF_FFFF;
          addr_d     = result_addr;
          state_d    = S_RD_ADDR;
        end
      end
      S_RD_ADDR: state_d = S_RD_DATA;
      S_RD_DATA: begin
        // Strict compare keeps the lowest index on ties.
        if (hit_best) begin
          bhash_d  = mem_read_data;
          bnonce_d = idx_q;
        end
        if (hit_tgt) begin
          cnt_d   = cnt_q + 8'd1;
          found_d = 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          // Header uses the next-state values so the last word is already folded in.
          we_d    = 1'b1;
          addr_d  = rep_base_q;
          wdata_d = {found_d, 15'b0, cnt_d, bnonce_d};
          state_d = S_WR_HDR;
        end else begin
          idx_d   = idx_q + 8'd1;
          addr_d  = res_base_q + {8'd0, idx_q} + 16'd1;
          state_d = S_RD_ADDR;
        end
      end
      S_WR_HDR: begin
        addr_d  = rep_base_q + 16'd1;
        wdata_d = bhash_q;
        state_d = S_WR_HASH;
      end
      S_WR_HASH: begin
        we_d    = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= 8'd0;
      res_base_q <= 16'd0;
      rep_base_q <= 16'd0;
      target_q   <= 32'd0;
      found_q    <= 1'b0;
      cnt_q      <= 8'd0;
      bnonce_q   <= 8'd0;
      bhash_q    <= 32'hFFFF_FFFF;
      we_q       <= 1'b0;
      addr_q     <= 16'd0;
      wdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      res_base_q <= res_base_d;
      rep_base_q <= rep_base_d;
      target_q   <= target_d;
      found_q    <= found_d;
      cnt_q      <= cnt_d;
      bnonce_q   <= bnonce_d;
      bhash_q    <= bhash_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign done           = (state_q == S_IDLE);
  assign found          = found_q;
  assign match_count    = cnt_q;
  assign best_nonce     = bnonce_q;
  assign best_hash      = bhash_q;
  assign mem_clk        = clk;
  assign mem_we         = we_q;
  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;

endmodule

// File: tb/tb_nonce_result_scanner.sv
// Randomized and directed bench for nonce_result_scanner against a
// behavioural min/count model and a synchronous memory model.
module tb_nonce_result_scanner;
  localparam int NN = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] result_addr, report_addr;
  logic [31:0] target;
  logic        done, found, mem_clk, mem_we;
  logic [7:0]  match_count, best_nonce;
  logic [31:0] best_hash, mem_write_data, mem_read_data;
  logic [15:0] mem_addr;

  nonce_result_scanner #(.NUM_NONCES(NN)) dut (
    .clk(clk), .reset(reset), .start(start), .result_addr(result_addr),
    .report_addr(report_addr), .target(target), .done(done), .found(found),
    .match_count(match_count), .best_nonce(best_nonce), .best_hash(best_hash),
    .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_write_data;
    mem_read_data <= mem[mem_addr];
  end

  // Bus activity log, sampled mid-cycle.
  bit          log_en = 1'b0;
  logic [47:0] wq[$];
  logic [15:0] rq[$];
  always @(negedge clk) begin
    if (log_en) begin
      if (mem_we) wq.push_back({mem_addr, mem_write_data});
      else if (!done) rq.push_back(mem_addr);
    end
  end

  int total = 0;
  int bad = 0;
  logic [31:0] hv [NN];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_found"}, 32'(found), 32'd0);
    chk({tag, "_cnt"}, 32'(match_count), 32'd0);
    chk({tag, "_nonce"}, 32'(best_nonce), 32'd0);
    chk({tag, "_hash"}, best_hash, 32'hFFFF_FFFF);
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_wdata"}, mem_write_data, 32'd0);
  endtask

  task automatic run_scan(input string tag, input logic [15:0] rb, input logic [15:0] pb,
                          input logic [31:0] tg, input bit noise);
    logic [31:0] eb;
    logic [7:0]  en, ec;
    logic [31:0] hdr;
    int n, errs;
    eb = 32'hFFFF_FFFF; en = 8'd0; ec = 8'd0;
    for (int i = 0; i < NN; i++) begin
      mem[rb + 16'(i)] = hv[i];
      if (hv[i] < eb) begin eb = hv[i]; en = 8'(i); end
      if (hv[i] < tg) ec++;
    end
    hdr = {(ec != 0), 15'b0, ec, en};
    wq.delete(); rq.delete(); log_en = 1'b1;
    @(negedge clk);
    result_addr = rb; report_addr = pb; target = tg; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_done_fall"}, 32'(done), 32'd0);
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (noise) begin
        start = (n >= 3 && n <= 20) ? n[0] : 1'b0;
        target = $urandom; result_addr = 16'($urandom); report_addr = 16'($urandom);
      end
    end
    chk({tag, "_latency"}, 32'(n), 32'(2 * NN + 2));
    @(negedge clk);
    log_en = 1'b0;
    chk({tag, "_found"}, 32'(found), 32'(ec != 0));
    chk({tag, "_cnt"}, 32'(match_count), 32'(ec));
    chk({tag, "_nonce"}, 32'(best_nonce), 32'(en));
    chk({tag, "_hash"}, best_hash, eb);
    chk({tag, "_nwr"}, 32'(wq.size()), 32'd2);
    if (wq.size() == 2) begin
      chk({tag, "_wr0_addr"}, 32'(wq[0][47:32]), 32'(pb));
      chk({tag, "_wr0_data"}, wq[0][31:0], hdr);
      chk({tag, "_wr1_addr"}, 32'(wq[1][47:32]), 32'(pb + 16'd1));
      chk({tag, "_wr1_data"}, wq[1][31:0], eb);
    end
    chk({tag, "_mem_hdr"}, mem[pb], hdr);
    chk({tag, "_mem_hash"}, mem[pb + 16'd1], eb);
    chk({tag, "_nrd"}, 32'(rq.size()), 32'(2 * NN));
    errs = 0;
    for (int j = 0; j < rq.size() && j < 2 * NN; j++)
      if (rq[j] !== rb + 16'(j / 2)) errs++;
    chk({tag, "_rd_seq"}, 32'(errs), 32'd0);
    start = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; result_addr = '0; report_addr = '0; target = '0;
    repeat (3) @(posedge clk);
    #1 chk_reset_vals("rst");
    @(negedge clk) reset = 1'b0;
    @(negedge clk) chk_reset_vals("idle");

    for (int i = 0; i < NN; i++) hv[i] = 32'(100 - i);
    run_scan("desc", 16'h0100, 16'h0200, 32'd90, 1'b0);

    for (int i = 0; i < NN; i++) hv[i] = 32'h0000_1000;
    run_scan("tie", 16'h0300, 16'h0400, 32'h0000_1000, 1'b0);

    for (int i = 0; i < NN; i++) hv[i] = (i == 7) ? 32'd0 : 32'hFFFF_FFFF;
    run_scan("one", 16'h0500, 16'h0600, 32'd1, 1'b0);

    for (int i = 0; i < NN; i++) hv[i] = 32'hFFFF_FFFF;
    run_scan("allff", 16'h0700, 16'h0800, 32'd0, 1'b0);

    for (int i = 0; i < NN; i++) hv[i] = $urandom_range(1000, 0);
    run_scan("allq", 16'h0900, 16'h0A00, 32'hFFFF_FFFF, 1'b0);

    for (int i = 0; i < NN; i++) hv[i] = $urandom;
    run_scan("wrap", 16'hFFF8, 16'h1000, 32'h8000_0000, 1'b0);

    for (int i = 0; i < NN; i++) hv[i] = $urandom_range(500, 0);
    run_scan("noise", 16'h1100, 16'h1200, 32'd250, 1'b1);

    // Reset while reading word 9; the report slot must stay untouched.
    for (int i = 0; i < NN; i++) begin hv[i] = 32'(i); mem[16'h1300 + 16'(i)] = hv[i]; end
    mem[16'h1400] = 32'hDEAD_BEEF;
    wq.delete(); log_en = 1'b1;
    @(negedge clk);
    result_addr = 16'h1300; report_addr = 16'h1400; target = 32'd5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #2 reset = 1'b1;
    #1 chk_reset_vals("midrst");
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    log_en = 1'b0;
    chk("midrst_nwr", 32'(wq.size()), 32'd0);
    chk("midrst_mem", mem[16'h1400], 32'hDEAD_BEEF);
    run_scan("after_rst", 16'h1300, 16'h1400, 32'd5, 1'b0);

    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(3, 0);
      for (int i = 0; i < NN; i++)
        hv[i] = (n == 0) ? $urandom : 32'($urandom_range(64, 0));
      run_scan("rand", 16'($urandom), 16'h2000 + 16'(k * 4),
               (k == 3) ? 32'd0 : 32'($urandom_range(70, 0)), k[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
